stat_poll: RTL and testbench
============================

# stat_poll

Statistics poller: the reading side of the per-flow packet-statistics read-and-clear interface. It sweeps flow numbers 0..FLOW_CNT-1, issues one read strobe per flow, and captures the returned counter. Each result is forwarded as a (flow, count) record on a valid/ready output stream toward the host/export path. It sits next to the statistics accumulator and is its only read initiator.

## Interface
- A_WIDTH, 10, flow-number width.
- D_WIDTH, 32, counter width.
- FLOW_CNT, 1024, number of flows swept (1..2**A_WIDTH).
- TIMEOUT, 15, max cycles waited for a response per flow (>=2).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle start of a sweep; ignored unless idle.
- cont_i  in  1  continuous mode, sampled at end of sweep.
- skip_zero_i  in  1  suppress output records whose count is 0.
- rd_stb_o  out  1  read request pulse to the accumulator.
- rd_flow_num_o  out  A_WIDTH  flow number; valid with rd_stb_o.
- rd_data_i  in  D_WIDTH  returned, cleared counter value.
- rd_data_val_i  in  1  one-cycle response strobe.
- out_flow_o  out  A_WIDTH  record flow number.
- out_data_o  out  D_WIDTH  record count.
- out_val_o  out  1  record valid.
- out_ready_i  in  1  record accepted when out_val_o && out_ready_i.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse at end of each sweep.
- timeout_cnt_o  out  16  saturating count of timed-out reads.

## Operation
- FSM states: IDLE, REQ, WAIT, PUSH, DONE.
- IDLE: on start_i, set flow=0 and go to REQ.
- REQ: assert rd_stb_o for exactly one cycle with rd_flow_num_o=flow, clear the wait counter, then go to WAIT.
- WAIT: the wait counter increments each cycle.
  - On rd_data_val_i, capture rd_data_i into out_data_o and flow into out_flow_o.
  - If skip_zero_i && rd_data_i==0, go to NEXT handling; otherwise go to PUSH.
  - If the counter reaches TIMEOUT without a response, increment timeout_cnt_o (saturating at 16'hFFFF), push no record, and go to NEXT handling.
- PUSH: hold out_val_o=1 with stable out_flow_o and out_data_o until out_ready_i, then go to NEXT handling.
- NEXT handling (a transition, not a separate state):
  - If flow==FLOW_CNT-1, go to DONE.
  - Otherwise flow+1 and go to REQ.
- DONE: pulse done_o for one cycle.
  - If cont_i, set flow=0 and go to REQ.
  - Otherwise go to IDLE.
- Only one read is outstanding at any time. No rd_stb_o is issued while a record is pending, so no response data is ever dropped.
- rd_data_val_i outside WAIT is ignored. The accumulator is responsible for not responding late; after a timeout the poller moves on.
- busy_o=1 in every state except IDLE.
- skip_zero_i and cont_i are sampled at the point of use, not latched at start.

## Timing
- All outputs are registered.
- Reset values: rd_stb_o=0, rd_flow_num_o=0, out_flow_o=0, out_data_o=0, out_val_o=0, busy_o=0, done_o=0, timeout_cnt_o=0, FSM=IDLE.
- start_i at cycle t gives rd_stb_o at t+1 for flow 0.
- rd_data_val_i at cycle t gives out_val_o=1 at t+1.
- Acceptance at cycle t gives rd_stb_o for the next flow at t+1 (or done_o at t+1 if last flow).
- Minimum spacing between rd_stb_o pulses: REQ + WAIT(>=1) + PUSH = 3 cycles with out_ready_i held high and a 1-cycle responder.
- The same-cycle response (rd_data_val_i in the REQ cycle) is ignored. The earliest accepted response is 1 cycle after rd_stb_o.
- A timeout is declared at the TIMEOUT-th WAIT cycle without response. The next rd_stb_o follows 1 cycle later.
- rst_i asserted mid-sweep: all outputs drop to reset values immediately (async). The sweep is abandoned, and the next sweep needs a new start_i.
- The flow counter stops at FLOW_CNT-1 and never wraps within a sweep. Sweep restart resets it to 0.

## Test plan
- FLOW_CNT=4, responder returns 10,20,30,40 one cycle after each strobe, out_ready_i=1 -> records (0,10),(1,20),(2,30),(3,40); strobes 3 cycles apart; done_o one cycle after the last acceptance; busy_o then low.
- Same stimulus with out_ready_i low for 5 cycles on record 1 -> record 1 held stable; no rd_stb_o until it is accepted; no data lost.
- skip_zero_i=1, responses 0,7,0,9 -> only (1,7),(3,9) emitted; done_o still pulses after flow 3.
- Responder silent for flow 2, TIMEOUT=15 -> no record for flow 2; timeout_cnt_o=1; rd_stb_o for flow 3 exactly 16 cycles after flow 2's strobe.
- cont_i=1 -> done_o pulse followed next cycle by rd_stb_o for flow 0; start_i pulses while busy have no effect.
- rst_i asserted while in PUSH at flow 2 -> out_val_o, busy_o, timeout_cnt_o at 0 immediately; no strobe until a new start_i.

Source files
------------

// File: rtl/stat_poll.sv
// stat_poll: per-flow statistics read-and-clear poller.
// Sweeps flows 0..FLOW_CNT-1, issues one read strobe per flow, waits for the
// returned counter (bounded by TIMEOUT) and forwards each result as a
// (flow, count) record on a valid/ready stream. All outputs are registered.
module stat_poll #(
    parameter int A_WIDTH  = 10,
    parameter int D_WIDTH  = 32,
    parameter int FLOW_CNT = 1024,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               cont_i,
    input  logic               skip_zero_i,
    output logic               rd_stb_o,
    output logic [A_WIDTH-1:0] rd_flow_num_o,
    input  logic [D_WIDTH-1:0] rd_data_i,
    input  logic               rd_data_val_i,
    output logic [A_WIDTH-1:0] out_flow_o,
    output logic [D_WIDTH-1:0] out_data_o,
    output logic               out_val_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        timeout_cnt_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int                 WAIT_W    = $clog2(TIMEOUT);
    localparam logic [A_WIDTH-1:0] LAST_FLOW = A_WIDTH'(FLOW_CNT - 1);
    // Wait counter reads k-1 in the k-th WAIT cycle, so this value marks the
    // TIMEOUT-th cycle without a response.
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]         state_q, state_d;
    logic [A_WIDTH-1:0] flow_q, flow_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               rd_stb_q, rd_stb_d;
    logic [A_WIDTH-1:0] out_flow_q, out_flow_d;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;
    logic               out_val_q, out_val_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        tmo_q, tmo_d;
    logic               advance;

    // Next-state and next-output logic; registered outputs are derived from the next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        flow_d     = flow_q;
        wait_d     = wait_q;
        out_flow_d = out_flow_q;
        out_data_d = out_data_q;
        tmo_d      = tmo_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    flow_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Strobe is on this cycle; a response arriving now is ignored.
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (rd_data_val_i) begin
                    out_data_d = rd_data_i;
                    out_flow_d = flow_q;
                    if (skip_zero_i && (rd_data_i == '0)) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_PUSH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    if (tmo_q != 16'hFFFF) begin
                        tmo_d = tmo_q + 16'd1;
                    end
                    advance = 1'b1;
                end
            end
            S_PUSH: begin
                if (out_ready_i) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                if (cont_i) begin
                    flow_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Move to the next flow, or finish the sweep; the flow counter never wraps.
        if (advance) begin
            if (flow_q == LAST_FLOW) begin
                state_d = S_DONE;
            end else begin
                flow_d  = flow_q + 1'b1;
                state_d = S_REQ;
            end
        end

        rd_stb_d  = (state_d == S_REQ);
        out_val_d = (state_d == S_PUSH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q    <= S_IDLE;
            flow_q     <= '0;
            wait_q     <= '0;
            rd_stb_q   <= 1'b0;
            out_flow_q <= '0;
            out_data_q <= '0;
            out_val_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            flow_q     <= flow_d;
            wait_q     <= wait_d;
            rd_stb_q   <= rd_stb_d;
            out_flow_q <= out_flow_d;
            out_data_q <= out_data_d;
            out_val_q  <= out_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
        end
    end

    // flow_q only changes on entry to REQ, so it is stable while the strobe is high.
    assign rd_stb_o      = rd_stb_q;
    assign rd_flow_num_o = flow_q;
    assign out_flow_o    = out_flow_q;
    assign out_data_o    = out_data_q;
    assign out_val_o     = out_val_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_stat_poll.sv
// tb_stat_poll: scoreboard bench for stat_poll with a 4-flow sweep.
module tb_stat_poll;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FC = 4;
    localparam int TO = 15;

    typedef struct {
        logic [AW-1:0] flow;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          cont_i;
    logic          skip_zero_i;
    logic          rd_stb_o;
    logic [AW-1:0] rd_flow_num_o;
    logic [DW-1:0] rd_data_i;
    logic          rd_data_val_i;
    logic [AW-1:0] out_flow_o;
    logic [DW-1:0] out_data_o;
    logic          out_val_o;
    logic          out_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   timeout_cnt_o;

    stat_poll #(.A_WIDTH(AW), .D_WIDTH(DW), .FLOW_CNT(FC), .TIMEOUT(TO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .cont_i        (cont_i),
        .skip_zero_i   (skip_zero_i),
        .rd_stb_o      (rd_stb_o),
        .rd_flow_num_o (rd_flow_num_o),
        .rd_data_i     (rd_data_i),
        .rd_data_val_i (rd_data_val_i),
        .out_flow_o    (out_flow_o),
        .out_data_o    (out_data_o),
        .out_val_o     (out_val_o),
        .out_ready_i   (out_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t exp_q[$];
    int   strb_cyc[$];
    int   strb_flow[$];
    int   done_cyc[$];
    int   acc_cyc[$];

    logic [DW-1:0] resp [FC];
    bit            silent [FC];
    int            ready_mode = 0;
    int            hold_cnt = 0;
    bit            pending = 0;
    logic [DW-1:0] pdata = '0;
    bit            stb_prev = 0;
    bit            held = 0;
    logic [AW-1:0] held_flow = '0;
    logic [DW-1:0] held_data = '0;
    int            start_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic push_rec(input int flow, input int data);
        rec_t r;
        r.flow = AW'(flow);
        r.data = DW'(data);
        exp_q.push_back(r);
    endtask

    task automatic set_resp(input int r0, input int r1, input int r2, input int r3);
        resp[0] = DW'(r0);
        resp[1] = DW'(r1);
        resp[2] = DW'(r2);
        resp[3] = DW'(r3);
    endtask

    task automatic clear_logs();
        strb_cyc.delete();
        strb_flow.delete();
        done_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic do_start();
        @(negedge clk_i);
        start_i   = 1'b1;
        start_cyc = cyc;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) fail_now("done_wait", "no done_o within budget, required a pulse");
        #1;
    endtask

    // Responds one cycle after each strobe unless the flow is marked silent.
    initial begin
        rd_data_val_i = 1'b0;
        rd_data_i     = '0;
        forever begin
            @(negedge clk_i);
            rd_data_val_i = pending;
            rd_data_i     = pending ? pdata : '0;
            pending       = rd_stb_o && !silent[rd_flow_num_o[1:0]] && !rst_i;
            pdata         = resp[rd_flow_num_o[1:0]];
        end
    end

    // Strobe / done logger with protocol checks.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rd_stb_o) begin
                strb_cyc.push_back(cyc);
                strb_flow.push_back(int'(rd_flow_num_o));
                if (out_val_o) fail_now("stb_while_pending", "strobe with out_val_o=1, required none");
                if (stb_prev) fail_now("stb_width", "strobe high 2 cycles, required 1");
            end
            stb_prev = rd_stb_o;
            if (done_o) done_cyc.push_back(cyc);
        end
    end

    // Ready driver and scoreboard monitor.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (out_val_o && ready_mode == 1 && out_flow_o == AW'(1) && hold_cnt < 5) begin
                out_ready_i = 1'b0;
                hold_cnt++;
            end else if (out_val_o && ready_mode == 2 && out_flow_o == AW'(2)) begin
                out_ready_i = 1'b0;
            end else begin
                out_ready_i = 1'b1;
            end
            if (rst_i) held = 0;
            if (held) begin
                check("hold_val", longint'(out_val_o), 1);
                check("hold_flow", longint'(out_flow_o), longint'(held_flow));
                check("hold_data", longint'(out_data_o), longint'(held_data));
                held = 0;
            end
            if (out_val_o && !out_ready_i) begin
                held      = 1;
                held_flow = out_flow_o;
                held_data = out_data_o;
            end else if (out_val_o) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_record", "record presented, required none");
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    check("rec_flow", longint'(out_flow_o), longint'(e.flow));
                    check("rec_data", longint'(out_data_o), longint'(e.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        int d2;
        int sz;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        cont_i      = 1'b0;
        skip_zero_i = 1'b0;
        for (int i = 0; i < FC; i++) silent[i] = 0;
        set_resp(10, 20, 30, 40);

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_stb", longint'(rd_stb_o), 0);
        check("rst_flow_num", longint'(rd_flow_num_o), 0);
        check("rst_out_val", longint'(out_val_o), 0);
        check("rst_out_flow", longint'(out_flow_o), 0);
        check("rst_out_data", longint'(out_data_o), 0);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_done", longint'(done_o), 0);
        check("rst_tmo", longint'(timeout_cnt_o), 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // 1: basic sweep, ready always high
        clear_logs();
        for (int i = 0; i < FC; i++) push_rec(i, (i + 1) * 10);
        do_start();
        wait_done(100, d1);
        check("t1_nstb", strb_cyc.size(), 4);
        check("t1_first_stb", strb_cyc[0], start_cyc + 1);
        for (int i = 1; i < 4; i++) begin
            check("t1_stb_flow", strb_flow[i], i);
            check("t1_stb_gap", strb_cyc[i] - strb_cyc[i-1], 3);
        end
        check("t1_nacc", acc_cyc.size(), 4);
        check("t1_done_cyc", d1, acc_cyc[3] + 1);
        @(negedge clk_i);
        check("t1_busy_low", longint'(busy_o), 0);
        check("t1_done_low", longint'(done_o), 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: record 1 held by backpressure for 5 cycles
        clear_logs();
        ready_mode = 1;
        hold_cnt   = 0;
        for (int i = 0; i < FC; i++) push_rec(i, (i + 1) * 10);
        do_start();
        wait_done(100, d1);
        check("t2_nstb", strb_cyc.size(), 4);
        check("t2_gap01", strb_cyc[1] - strb_cyc[0], 3);
        check("t2_gap12", strb_cyc[2] - strb_cyc[1], 8);
        check("t2_gap23", strb_cyc[3] - strb_cyc[2], 3);
        check("t2_stb_after_acc", strb_cyc[2], acc_cyc[1] + 1);
        check("t2_sb_empty", exp_q.size(), 0);
        ready_mode = 0;

        // 3: skip-zero, responses 0,7,0,9
        clear_logs();
        skip_zero_i = 1'b1;
        set_resp(0, 7, 0, 9);
        push_rec(1, 7);
        push_rec(3, 9);
        do_start();
        wait_done(100, d1);
        check("t3_nstb", strb_cyc.size(), 4);
        check("t3_gap01", strb_cyc[1] - strb_cyc[0], 2);
        check("t3_gap12", strb_cyc[2] - strb_cyc[1], 3);
        check("t3_gap23", strb_cyc[3] - strb_cyc[2], 2);
        check("t3_ndone", done_cyc.size(), 1);
        check("t3_done_cyc", d1, strb_cyc[3] + 3);
        check("t3_sb_empty", exp_q.size(), 0);
        skip_zero_i = 1'b0;

        // 4: flow 2 silent -> timeout
        clear_logs();
        set_resp(10, 20, 30, 40);
        silent[2] = 1;
        push_rec(0, 10);
        push_rec(1, 20);
        push_rec(3, 40);
        do_start();
        wait_done(150, d1);
        check("t4_nstb", strb_cyc.size(), 4);
        check("t4_tmo_gap", strb_cyc[3] - strb_cyc[2], 16);
        check("t4_tmo_cnt", longint'(timeout_cnt_o), 1);
        check("t4_sb_empty", exp_q.size(), 0);
        silent[2] = 0;

        // 5: continuous mode, stray start pulses while busy
        clear_logs();
        cont_i = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < FC; i++) push_rec(i, (i + 1) * 10);
        do_start();
        repeat (3) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(100, d1);
        @(negedge clk_i);
        cont_i = 1'b0;
        wait_done(100, d2);
        sz = strb_cyc.size();
        check("t5_nstb", sz, 8);
        check("t5_restart_flow", strb_flow[4], 0);
        check("t5_restart_cyc", strb_cyc[4], d1 + 1);
        for (int i = 1; i < 8; i++) begin
            check("t5_stb_flow", strb_flow[i], i % 4);
            if (i != 4) check("t5_stb_gap", strb_cyc[i] - strb_cyc[i-1], 3);
        end
        check("t5_ndone", done_cyc.size(), 2);
        check("t5_tmo_kept", longint'(timeout_cnt_o), 1);
        @(negedge clk_i);
        check("t5_busy_low", longint'(busy_o), 0);
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: reset while record 2 is pending
        clear_logs();
        ready_mode = 2;
        push_rec(0, 10);
        push_rec(1, 20);
        do_start();
        d1 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (out_val_o && out_flow_o == AW'(2)) begin
                d1 = cyc;
                break;
            end
        end
        if (d1 < 0) fail_now("t6_push_wait", "flow 2 record never presented, required it");
        rst_i = 1'b1;
        #1;
        check("t6_out_val", longint'(out_val_o), 0);
        check("t6_busy", longint'(busy_o), 0);
        check("t6_tmo", longint'(timeout_cnt_o), 0);
        check("t6_stb", longint'(rd_stb_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i      = 1'b0;
        ready_mode = 0;
        clear_logs();
        repeat (10) @(negedge clk_i);
        check("t6_no_stb", strb_cyc.size(), 0);
        check("t6_sb_empty", exp_q.size(), 0);

        // Recovery sweep after a fresh start
        for (int i = 0; i < FC; i++) push_rec(i, (i + 1) * 10);
        do_start();
        wait_done(100, d1);
        check("t6_restart_stb", strb_cyc[0], start_cyc + 1);
        check("t6_restart_flow", strb_flow[0], 0);
        check("t6_restart_sb", exp_q.size(), 0);

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
